// File: rtl/fetch_unit.sv
// Fetch datapath: owns PC, MAR and IR, runs the instruction read handshake.
// Ports: control strobes in, mem req/ack out/in, instr/instr_valid/stall/pc/err out.
module fetch_unit #(
  parameter int          ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int          TIMEOUT  = 15,
  parameter logic [15:0] NOP_WORD = 16'h0000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              MAR_LOAD,
  input  logic              INCR_PC,
  input  logic              IR_LOAD,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [15:0]       instr,
  output logic              instr_valid,
  output logic              stall,
  output logic [ADDR_W-1:0] pc,
  output logic [1:0]        err
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] mar;
  logic [15:0]       ir;
  logic [7:0]        cnt;
  logic [8:0]        cnt_nxt;

  assign cnt_nxt  = {1'b0, cnt} + 9'd1;
  assign mem_addr = mar;
  assign instr    = ir;
  assign stall    = mem_req;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      mar         <= '0;
      ir          <= '0;
      cnt         <= '0;
      mem_req     <= 1'b0;
      instr_valid <= 1'b0;
      err         <= 2'b00;
    end else begin
      instr_valid <= 1'b0;

      if (pc_load)
        pc <= pc_in;
      else if (INCR_PC)
        pc <= pc + ADDR_W'(1);

      // MAR samples the pre-edge PC
      if (MAR_LOAD)
        mar <= pc;

      unique case (state)
        IDLE: begin
          if (IR_LOAD) begin
            state   <= REQ;
            mem_req <= 1'b1;
          end
        end
        REQ: begin
          cnt <= '0;
          if (IR_LOAD)
            err[1] <= 1'b1;
          if (mem_ack) begin
            ir          <= mem_rdata;
            state       <= IDLE;
            mem_req     <= 1'b0;
            instr_valid <= 1'b1;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (IR_LOAD)
            err[1] <= 1'b1;
          // a late ack on the final cycle still wins
          if (mem_ack) begin
            ir          <= mem_rdata;
            state       <= IDLE;
            mem_req     <= 1'b0;
            instr_valid <= 1'b1;
          end else if (cnt_nxt == 9'(TIMEOUT)) begin
            ir          <= NOP_WORD;
            err[0]      <= 1'b1;
            state       <= IDLE;
            mem_req     <= 1'b0;
            instr_valid <= 1'b1;
          end else begin
            cnt <= cnt_nxt[7:0];
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Datapath-side responder to the control unit's fetch signals (MAR_LOAD, INCR_PC, IR_LOAD).
- Owns PC, MAR and IR.
- Issues instruction-memory reads with a req/ack handshake and presents the fetched word as instr back to the control unit.
- Raises stall while a read is outstanding so the control unit can hold its state.

Parameters:
- ADDR_W, 16: width of PC, MAR and mem_addr.
- RESET_PC, 0: PC value after reset.
- TIMEOUT, 15: maximum cycles to wait for mem_ack before aborting (1..255).
- NOP_WORD, 16'h0000: value loaded into IR on a timed-out read.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- MAR_LOAD  in  1  MAR <= PC.
- INCR_PC  in  1  PC <= PC+1.
- IR_LOAD  in  1  start instruction read at MAR.
- pc_load  in  1  PC <= pc_in (jump); has priority over INCR_PC.
- pc_in  in  ADDR_W  jump target.
- mem_req  out  1  read request to instruction memory.
- mem_addr  out  ADDR_W  read address; always equals MAR.
- mem_rdata  in  16  read data, valid while mem_ack=1.
- mem_ack  in  1  read completion, single-cycle pulse.
- instr  out  16  IR contents, fed to the control unit.
- instr_valid  out  1  one-cycle pulse the cycle after IR is updated.
- stall  out  1  read outstanding (pending or waiting).
- pc  out  ADDR_W  current PC.
- err  out  2  sticky error flags: [0] timeout, [1] IR_LOAD overrun.

Behaviour:
- Reset (asynchronous assert, synchronous deassert on the next clk edge):
  - PC = RESET_PC; MAR = 0; IR = 0.
  - mem_req = 0, instr_valid = 0, stall = 0, err = 0.
  - FSM in IDLE; wait counter = 0.
- PC update, per clk:
  - pc_load → PC <= pc_in.
  - else INCR_PC → PC <= PC+1, wrapping from all-ones to 0.
  - else hold.
- MAR update:
  - MAR_LOAD → MAR <= PC, using the PC value before that edge's update.
  - MAR_LOAD, INCR_PC and IR_LOAD in the same cycle is the normal fetch: MAR gets the old PC and PC advances.
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - IR_LOAD → REQ; stall = 1 from the following cycle.
  - The read address is the MAR value after that edge, so a same-cycle MAR_LOAD is honoured.
- REQ:
  - mem_req = 1; wait counter cleared.
  - mem_ack=1 in this cycle → IR <= mem_rdata, go to IDLE.
  - else → WAIT.
- WAIT:
  - mem_req stays 1; counter increments each cycle.
  - mem_ack → IR <= mem_rdata, go to IDLE.
  - Counter reaches TIMEOUT with no ack → IR <= NOP_WORD, err[0] <= 1, go to IDLE.
- Exit from REQ/WAIT: mem_req and stall drop in the cycle after the ack/timeout edge; instr_valid = 1 for exactly that one cycle.
- Latency: a zero-wait memory (ack in the first REQ cycle) gives instr updated 2 clks after IR_LOAD.
- mem_ack while in IDLE is ignored; IR is unchanged and no error is flagged.
- IR_LOAD while in REQ/WAIT:
  - Ignored, no request is queued; err[1] <= 1.
  - MAR_LOAD during a read still updates MAR, but mem_addr is then undefined-for-protocol. The control unit must not do this; the bench checks that err does not mask it.
- err bits clear only on reset.
- Reset mid-read: mem_req drops immediately (asynchronous); a later ack is ignored.
- instr holds its value between fetches; the control unit samples it during DECODE/EXEC.

Test Plan:
- Reset with RESET_PC=16'h0010, then one fetch (MAR_LOAD+INCR_PC+IR_LOAD), memory acks in the REQ cycle with 16'hA00B → mem_addr=16'h0010, instr=16'hA00B 2 clks after IR_LOAD, pc=16'h0011, one instr_valid pulse.
- Memory acks 3 cycles late → mem_req high for 4 cycles, stall high throughout, IR updated only on the ack cycle.
- No ack with TIMEOUT=4 → mem_req drops after the abort, instr=NOP_WORD, err=2'b01, FSM back in IDLE and the next fetch succeeds.
- pc=16'hFFFF with INCR_PC → pc=16'h0000. Same cycle pc_load=1, pc_in=16'h0200 with INCR_PC → pc=16'h0200.
- IR_LOAD asserted again while in WAIT → request count unchanged, err[1]=1, original read completes normally.
- reset_n pulled low during WAIT → mem_req and stall fall without a clock edge, all outputs at reset values, a post-reset ack leaves IR=0.
